// File: rtl/audio_i2s_pkg.sv
`default_nettype none
// ============================================================================
// Package  : audio_i2s_pkg
// Summary  : Shared constants and types for the I2S audio blocks.
// Revision : 1.0 - initial release
// ============================================================================
package audio_i2s_pkg;

    localparam int DATA_W_DEF   = 24;
    localparam int SLOT_W_DEF   = 32;
    localparam int BCLK_DIV_DEF = 6;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        RUN   = ST_RUN,
        DRAIN = ST_DRAIN
    } tx_state_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] left;
        logic [DATA_W_DEF-1:0] right;
    } audio_pair_t;

endpackage
`default_nettype wire

// File: rtl/audio_i2s_clkgen.sv
`default_nettype none
// ============================================================================
// Module   : audio_i2s_clkgen
// Summary  : BCLK/LRCLK generator with bit position tracking, shared by the
//            I2S transmit and receive paths.
// Revision : 1.0 - initial release
// ============================================================================
module audio_i2s_clkgen
    import audio_i2s_pkg::*;
#(
    parameter int SLOT_W   = SLOT_W_DEF,
    parameter int BCLK_DIV = BCLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic cnt_en,
    input  logic cnt_clr,
    output logic bclk,
    output logic lrclk,
    output logic fall_edge,
    output logic frame_wrap
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int BIT_W = $clog2(2 * SLOT_W);

    localparam logic [DIV_W-1:0] c_DIV_MAX  = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] c_DIV_HALF = DIV_W'(BCLK_DIV / 2);
    localparam logic [BIT_W-1:0] c_BIT_MAX  = BIT_W'(2 * SLOT_W - 1);
    localparam logic [BIT_W-1:0] c_SLOT     = BIT_W'(SLOT_W);

    logic [DIV_W-1:0] r_div_cnt;
    logic [DIV_W-1:0] w_div_nxt;
    logic [BIT_W-1:0] r_bit_cnt;
    logic [BIT_W-1:0] w_bit_nxt;
    logic             r_bclk;
    logic             r_lrclk;

    assign fall_edge  = cnt_en && (r_div_cnt == c_DIV_MAX);
    assign frame_wrap = fall_edge && (r_bit_cnt == c_BIT_MAX);
    assign bclk       = r_bclk;
    assign lrclk      = r_lrclk;

    always_comb begin
        w_div_nxt = r_div_cnt;
        w_bit_nxt = r_bit_cnt;
        if (cnt_clr) begin
            w_div_nxt = '0;
            w_bit_nxt = '0;
        end else if (cnt_en) begin
            if (fall_edge) begin
                w_div_nxt = '0;
                w_bit_nxt = frame_wrap ? '0 : r_bit_cnt + BIT_W'(1);
            end else begin
                w_div_nxt = r_div_cnt + DIV_W'(1);
            end
        end
    end

    // Pin levels are registered from the next counter values so they stay
    // aligned with the counters yet never come from combinational decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_bclk    <= 1'b0;
            r_lrclk   <= 1'b0;
        end else begin
            r_div_cnt <= w_div_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_bclk    <= (w_div_nxt >= c_DIV_HALF);
            r_lrclk   <= (w_bit_nxt >= c_SLOT);
        end
    end

endmodule
`default_nettype wire

// File: rtl/audio_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : audio_i2s_tx
// Summary  : I2S master transmitter: stereo valid/ready stream to DACDAT.
//            Build option AUDIO_I2S_TX_UNDERFLOW_REPEAT_EN: repeat the last
//            pair on underflow instead of muting.
// Revision : 1.0 - initial release
// ============================================================================
module audio_i2s_tx
    import audio_i2s_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int SLOT_W   = SLOT_W_DEF,
    parameter int BCLK_DIV = BCLK_DIV_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic              enable,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              i2s_bclk,
    output logic              i2s_lrclk,
    output logic              i2s_dacdat,
    output logic              underflow,
    output logic              frame_start
);

    localparam int FRAME_W = 2 * SLOT_W;
    localparam int PAD_W   = SLOT_W - 1 - DATA_W;

    tx_state_t          r_state;
    tx_state_t          w_state_nxt;
    logic               r_lock_s1;
    logic               r_lock_s2;
    logic               w_run_ok;
    logic               w_load;
    logic               w_accept;
    logic               w_fall_edge;
    logic               w_frame_wrap;
    logic               w_cnt_en;
    logic               w_cnt_clr;
    logic               r_full;
    logic [DATA_W-1:0]  r_buf_l;
    logic [DATA_W-1:0]  r_buf_r;
    logic [DATA_W-1:0]  w_ld_l;
    logic [DATA_W-1:0]  w_ld_r;
    logic [SLOT_W-1:0]  w_slot_l;
    logic [SLOT_W-1:0]  w_slot_r;
    logic [FRAME_W-1:0] w_image;
    logic [FRAME_W-1:0] r_shift;
    logic               r_dacdat;
    logic               r_underflow;
    logic               r_frame_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock_s1 <= 1'b0;
            r_lock_s2 <= 1'b0;
        end else begin
            r_lock_s1 <= pll_locked;
            r_lock_s2 <= r_lock_s1;
        end
    end

    assign w_run_ok = enable && r_lock_s2;
    assign w_accept = s_valid && s_ready;
    assign s_ready  = !r_full && (r_state == RUN);

    // A frame boundary with enable low ends the run instead of loading.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        if (!r_lock_s2) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_run_ok) begin
                        w_state_nxt = RUN;
                        w_load      = 1'b1;
                    end
                end
                RUN: begin
                    if (w_frame_wrap) begin
                        if (enable) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else if (!enable) begin
                        w_state_nxt = DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_frame_wrap) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign w_cnt_en  = (r_state != IDLE);
    assign w_cnt_clr = (r_state == IDLE) || (w_state_nxt == IDLE);

    audio_i2s_clkgen #(
        .SLOT_W   (SLOT_W),
        .BCLK_DIV (BCLK_DIV)
    ) u_clkgen (
        .clk        (clk),
        .rst        (rst),
        .cnt_en     (w_cnt_en),
        .cnt_clr    (w_cnt_clr),
        .bclk       (i2s_bclk),
        .lrclk      (i2s_lrclk),
        .fall_edge  (w_fall_edge),
        .frame_wrap (w_frame_wrap)
    );

`ifdef AUDIO_I2S_TX_UNDERFLOW_REPEAT_EN
    logic [DATA_W-1:0] r_last_l;
    logic [DATA_W-1:0] r_last_r;

    assign w_ld_l = r_full ? r_buf_l : r_last_l;
    assign w_ld_r = r_full ? r_buf_r : r_last_r;

    // The held pair is forgotten whenever the transmitter leaves the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_l <= '0;
            r_last_r <= '0;
        end else if (w_state_nxt == IDLE) begin
            r_last_l <= '0;
            r_last_r <= '0;
        end else if (w_load) begin
            r_last_l <= w_ld_l;
            r_last_r <= w_ld_r;
        end
    end
`else
    assign w_ld_l = r_full ? r_buf_l : '0;
    assign w_ld_r = r_full ? r_buf_r : '0;
`endif

    // Slot image: one-bit I2S delay, MSB-first sample, zero padding.
    assign w_slot_l = SLOT_W'({1'b0, w_ld_l}) << PAD_W;
    assign w_slot_r = SLOT_W'({1'b0, w_ld_r}) << PAD_W;
    assign w_image  = {w_slot_l, w_slot_r};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full  <= 1'b0;
            r_buf_l <= '0;
            r_buf_r <= '0;
        end else if (!r_lock_s2) begin
            r_full <= 1'b0;
        end else if (w_accept) begin
            r_full  <= 1'b1;
            r_buf_l <= s_left;
            r_buf_r <= s_right;
        end else if (w_load) begin
            r_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_shift       <= '0;
            r_dacdat      <= 1'b0;
            r_underflow   <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_frame_start <= w_load;
            r_underflow   <= w_load && !r_full;
            if (w_state_nxt == IDLE) begin
                r_shift  <= '0;
                r_dacdat <= 1'b0;
            end else if (w_load) begin
                r_shift  <= {w_image[FRAME_W-2:0], 1'b0};
                r_dacdat <= w_image[FRAME_W-1];
            end else if (w_fall_edge) begin
                r_shift  <= {r_shift[FRAME_W-2:0], 1'b0};
                r_dacdat <= r_shift[FRAME_W-1];
            end
        end
    end

    assign i2s_dacdat  = r_dacdat;
    assign underflow   = r_underflow;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_audio_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_i2s_tx
// Summary  : Self-checking bench for audio_i2s_tx; recovers frames the way a
//            codec would (on BCLK rising edges) and compares with a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_i2s_tx;
    import audio_i2s_pkg::*;

    localparam int DATA_W     = DATA_W_DEF;
    localparam int SLOT_W     = SLOT_W_DEF;
    localparam int BCLK_DIV   = BCLK_DIV_DEF;
    localparam int FRAME_BITS = 2 * SLOT_W;
    localparam int FRAME_CLKS = FRAME_BITS * BCLK_DIV;

    logic              clk = 1'b0;
    logic              rst;
    logic              pll_locked;
    logic              enable;
    logic [DATA_W-1:0] s_left;
    logic [DATA_W-1:0] s_right;
    logic              s_valid;
    logic              s_ready;
    logic              i2s_bclk;
    logic              i2s_lrclk;
    logic              i2s_dacdat;
    logic              underflow;
    logic              frame_start;

    always #5 clk = ~clk;

    audio_i2s_tx #(
        .DATA_W   (DATA_W),
        .SLOT_W   (SLOT_W),
        .BCLK_DIV (BCLK_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .enable      (enable),
        .s_left      (s_left),
        .s_right     (s_right),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .i2s_bclk    (i2s_bclk),
        .i2s_lrclk   (i2s_lrclk),
        .i2s_dacdat  (i2s_dacdat),
        .underflow   (underflow),
        .frame_start (frame_start)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          frame_cnt = 0;
    audio_pair_t m_buf, m_last, cur_exp, acc_pair;
    logic        m_full   = 1'b0;
    logic        acc_pend = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({i2s_bclk, i2s_lrclk, i2s_dacdat, s_ready, underflow, frame_start});
    endfunction

    // Reference model: one-deep stereo buffer; a load takes the buffered pair,
    // else underflows with the fill pair. A handshake seen on the same edge
    // as a load only reaches the buffer after that load.
    always @(negedge clk) begin
        if (rst) begin
            m_full   = 1'b0;
            m_last   = '0;
            acc_pend = 1'b0;
        end else begin
            if (frame_start) begin
                frame_cnt++;
                chk("underflow_at_load", 64'(underflow), 64'(!m_full));
                if (m_full) begin
                    cur_exp = m_buf;
                end else begin
`ifdef AUDIO_I2S_TX_UNDERFLOW_REPEAT_EN
                    cur_exp = m_last;
`else
                    cur_exp = '0;
`endif
                end
                m_last = cur_exp;
                m_full = 1'b0;
            end else begin
                chk("underflow_quiet", 64'(underflow), 64'd0);
            end
            if (acc_pend) begin
                m_full = 1'b1;
                m_buf  = acc_pair;
            end
            acc_pend = s_valid && s_ready;
            acc_pair = {s_left, s_right};
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_frame_start(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < FRAME_CLKS + 50; i++) begin
            @(negedge clk);
            if (frame_start) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_frame_start_seen"}, 64'(ok), 64'd1);
    endtask

    task automatic check_frame(input string tag);
        bit                    ok;
        logic [FRAME_BITS-1:0] data_w, lr_w, exp_w, exp_lr;
        int                    gap, gap_bad, want;
        logic                  prev, rise;
        wait_frame_start(tag, ok);
        if (!ok) return;
        data_w  = '0;
        lr_w    = '0;
        gap_bad = 0;
        prev    = i2s_bclk;
        for (int b = 0; b < FRAME_BITS; b++) begin
            gap  = 0;
            rise = 1'b0;
            do begin
                @(negedge clk);
                gap++;
                rise = i2s_bclk && !prev;
                prev = i2s_bclk;
            end while (!rise && gap < 4 * BCLK_DIV);
            if (!rise) begin
                gap_bad++;
                break;
            end
            data_w = {data_w[FRAME_BITS-2:0], i2s_dacdat};
            lr_w   = {lr_w[FRAME_BITS-2:0], i2s_lrclk};
            want   = (b == 0) ? BCLK_DIV / 2 : BCLK_DIV;
            if (gap != want) gap_bad++;
        end
        exp_w  = (FRAME_BITS'(cur_exp.left)  << (FRAME_BITS - 1 - DATA_W)) |
                 (FRAME_BITS'(cur_exp.right) << (SLOT_W - 1 - DATA_W));
        exp_lr = {{SLOT_W{1'b0}}, {SLOT_W{1'b1}}};
        chk({tag, "_data"}, 64'(data_w), 64'(exp_w));
        chk({tag, "_lrclk"}, 64'(lr_w), 64'(exp_lr));
        chk({tag, "_bclk_timing"}, 64'(gap_bad), 64'd0);
    endtask

    task automatic send_pair(input string tag, input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        bit ok;
        s_left  = l;
        s_right = r;
        s_valid = 1'b1;
        ok      = 1'b0;
        for (int i = 0; i < FRAME_CLKS + 50; i++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_accepted"}, 64'(ok), 64'd1);
        if (ok) begin
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic feed(input int n);
        bit ok;
        int last_acc;
        last_acc = 0;
        s_valid  = 1'b1;
        for (int k = 0; k < n; k++) begin
            s_left  = DATA_W'($urandom);
            s_right = DATA_W'($urandom);
            ok      = 1'b0;
            for (int i = 0; i < FRAME_CLKS + 50; i++) begin
                @(negedge clk);
                if (s_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk("stream_accepted", 64'(ok), 64'd1);
            if (!ok) break;
            if (k >= 2) chk("accept_interval", 64'(cyc - last_acc), 64'(FRAME_CLKS));
            last_acc = cyc;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
    endtask

    initial begin
        bit ok;
        int fs_before;
        rst        = 1'b1;
        pll_locked = 1'b0;
        enable     = 1'b0;
        s_valid    = 1'b0;
        s_left     = '0;
        s_right    = '0;
        step(4);
        chk("reset_outputs", outs(), 64'd0);
        rst = 1'b0;
        step(3);
        chk("idle_unlocked", outs(), 64'd0);

        pll_locked = 1'b1;
        enable     = 1'b1;
        check_frame("first_frame");
        send_pair("pair_a", 24'hA5A5A5, 24'h123456);
        check_frame("pair_a");
        check_frame("underflow_fill");

        fork
            feed(4);
            begin
                check_frame("stream0");
                check_frame("stream1");
                check_frame("stream2");
            end
        join
        check_frame("stream3");
        check_frame("hold_after_stream");

        // Drop enable at bit 10; the frame must finish before going quiet.
        wait_frame_start("drain", ok);
        step(62);
        enable = 1'b0;
        step(2);
        chk("drain_ready_low", 64'(s_ready), 64'd0);
        step(FRAME_CLKS - 1 - 64);
        chk("drain_last_bit_clocks", 64'({i2s_bclk, i2s_lrclk}), 64'd3);
        step(1);
        chk("drain_idle_outputs", outs(), 64'd0);
        fs_before = frame_cnt;
        step(FRAME_CLKS + 16);
        chk("drain_no_restart", 64'(frame_cnt), 64'(fs_before));
        chk("drain_still_idle", outs(), 64'd0);
        m_last = '0;

        enable = 1'b1;
        check_frame("restart");
        wait_frame_start("pre_unlock", ok);
        step(20);
        send_pair("pair_b", DATA_W'($urandom), DATA_W'($urandom));
        step(100);
        pll_locked = 1'b0;
        step(3);
        chk("unlock_outputs", outs(), 64'd0);
        m_full   = 1'b0;
        m_last   = '0;
        acc_pend = 1'b0;
        step(10);
        chk("unlock_held_idle", outs(), 64'd0);
        pll_locked = 1'b1;
        check_frame("relock");

        wait_frame_start("pre_reset", ok);
        step(250);
        chk("pre_reset_lrclk", 64'(i2s_lrclk), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_immediate", outs(), 64'd0);
        enable = 1'b0;
        step(3);
        chk("async_reset_held", outs(), 64'd0);
        rst = 1'b0;
        step(6);
        chk("post_reset_idle", outs(), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/audio_i2s_tx.md
Name: audio_i2s_tx

Overview:
I2S master transmitter (DAC direction) clocked by the 18.432 MHz audio PLL output. It divides the audio clock into BCLK (3.072 MHz) and LRCLK (48 kHz), and serializes stereo sample pairs from a valid/ready stream to the codec DACDAT pin. It consumes the PLL `locked` indication so that it only drives the codec from a stable clock. It sits between the Nios-side audio FIFO and the codec pins.

Parameters:
- DATA_W, 24: sample width in bits; must satisfy DATA_W <= SLOT_W-1.
- SLOT_W, 32: BCLK periods per channel slot; one frame = 2*SLOT_W BCLKs.
- BCLK_DIV, 6: clk cycles per BCLK period; even, >= 2.

Ports:
- clk, input, 1: audio clock, 18.432 MHz, from the PLL outclk_0.
- rst, input, 1: asynchronous, active-high reset.
- pll_locked, input, 1: PLL locked; synchronized internally with a 2-flop synchronizer.
- enable, input, 1: software run request.
- s_left, input, DATA_W: left sample, two's complement.
- s_right, input, DATA_W: right sample.
- s_valid, input, 1: sample pair valid.
- s_ready, output, 1: pair accepted when s_valid && s_ready.
- i2s_bclk, output, 1: bit clock.
- i2s_lrclk, output, 1: word select; 0 = left, 1 = right.
- i2s_dacdat, output, 1: serial data.
- underflow, output, 1: one-cycle pulse when a frame starts with an empty buffer.
- frame_start, output, 1: one-cycle pulse at each frame load.

Behaviour:
- Reset values: all outputs 0, state IDLE, buffer empty, counters 0.
- run_ok = enable && locked_sync.
- States:
  - IDLE: i2s_bclk, i2s_lrclk and i2s_dacdat are held at 0. Go to RUN when run_ok=1; counters restart at 0.
  - RUN: clocks toggle. Go to DRAIN when enable=0.
  - DRAIN: the current frame completes. At the frame end (bit_cnt wrap) go to IDLE.
  - Any state: locked_sync=0 forces IDLE on the next cycle, the buffer is flushed, and no frame_start is issued.
- Divider:
  - div_cnt counts 0..BCLK_DIV-1 and wraps.
  - i2s_bclk = 1 when div_cnt >= BCLK_DIV/2, else 0.
  - A BCLK falling edge occurs at the div_cnt wrap. bit_cnt (0..2*SLOT_W-1) advances there and wraps.
- Frame load: at the falling edge where bit_cnt becomes 0, frame_start pulses.
  - If the buffer is full, its pair goes into the shift registers and the buffer empties.
  - If the buffer is empty, underflow pulses and the fill data defined under Optional Feature is loaded.
- Outputs update only on BCLK falling edges, so the codec samples on rising edges.
- i2s_lrclk = (bit_cnt >= SLOT_W).
- Slot position p = bit_cnt mod SLOT_W:
  - p = 0: i2s_dacdat = 0 (standard I2S one-bit delay).
  - p = 1..DATA_W: data bit DATA_W-p, MSB first.
  - p > DATA_W: 0.
- Buffer: a single stereo register with a full flag.
  - s_ready = !full && state==RUN.
  - A handshake in the same cycle as a frame load with an empty buffer: the load sees the old (empty) state and underflows; the new pair is stored, and full=1.
  - A handshake in the same cycle as a load with a full buffer cannot occur, because s_ready=0 while full.
- Latency: an accepted pair appears on DACDAT at the next frame start. Its first data bit follows frame_start by BCLK_DIV cycles.
- Frame period = 2*SLOT_W*BCLK_DIV clk cycles (384 at defaults, i.e. 48 kHz).

Optional Feature:
- Macro AUDIO_I2S_TX_UNDERFLOW_REPEAT_EN.
- Defined: on underflow, the previously transmitted pair is retransmitted (last-sample hold). It is zeros if nothing has been sent since reset or IDLE.
- Undefined: on underflow, zeros are transmitted (mute).
- The underflow pulse is identical in both builds.

Decomposition:
- Package audio_i2s_pkg:
  - constants DATA_W_DEF, SLOT_W_DEF, BCLK_DIV_DEF;
  - state enum typedef tx_state_t {IDLE, RUN, DRAIN};
  - typedef audio_pair_t (struct of left/right, DATA_W each).
- Sub-module audio_i2s_clkgen: owns div_cnt and bit_cnt, and produces bclk, lrclk, fall_edge and frame_wrap. A future audio_i2s_rx reuses it.

Test Plan:
- Defaults; locked=1, enable=1, one pair L=24'hA5A5A5, R=24'h123456 → at the first frame after acceptance, LRCLK is low for 32 BCLKs. DACDAT is 0 at p=0, then bits 1010_0101…, then 0 for p=25..31; right slot carries 0x123456; BCLK period is 6 clk.
- No input after one pair → the next frame_start coincides with an underflow pulse. DACDAT is all zeros in the mute build, and repeats A5A5A5/123456 when AUDIO_I2S_TX_UNDERFLOW_REPEAT_EN is defined.
- s_valid held high continuously → exactly one acceptance per 384 clk cycles and no underflow after the first frame.
- Deassert enable at bit_cnt=10 → the frame completes to bit_cnt=63, then BCLK, LRCLK and DACDAT go to 0 and s_ready=0.
- Drop pll_locked mid-frame → within 3 clk cycles the block is in IDLE with outputs 0 and the buffer flushed. On re-lock, the first frame starts with underflow.
- Assert rst mid-frame, asynchronously → all outputs go to 0 immediately, with no glitch back to the prior state.
